// File: rtl/updown_mod_counter.sv
// Up/down counter over [0, max_value] with parallel load, wrap or saturate at
// the range limits, a registered terminal-count pulse and sticky flags.
module updown_mod_counter #(
  parameter int unsigned           WIDTH       = 8,
  parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic [WIDTH-1:0] max_value,
  input  logic             saturate,
  input  logic             clear_flags,
  output logic [WIDTH-1:0] counter_out,
  output logic             terminal_count,
  output logic             overflow,
  output logic             underflow
);

  logic [WIDTH-1:0] count_nxt;
  logic             tc_nxt;
  logic             ovf_set;
  logic             unf_set;
  logic             ovf_nxt;
  logic             unf_nxt;

  // Next count, wrap pulse and flag-set events; load beats enable, idle holds.
  always_comb begin
    count_nxt = counter_out;
    tc_nxt    = 1'b0;
    ovf_set   = 1'b0;
    unf_set   = 1'b0;
    if (load) begin
      count_nxt = (load_value > max_value) ? max_value : load_value;
    end else if (enable) begin
      if (up_down) begin
        if (counter_out < max_value) begin
          count_nxt = counter_out + WIDTH'(1);
        end else begin
          ovf_set   = 1'b1;
          count_nxt = saturate ? max_value : '0;
          tc_nxt    = ~saturate;
        end
      end else begin
        if (counter_out != '0) begin
          count_nxt = counter_out - WIDTH'(1);
        end else begin
          unf_set   = 1'b1;
          count_nxt = saturate ? '0 : max_value;
          tc_nxt    = ~saturate;
        end
      end
    end
    ovf_nxt = ovf_set | (overflow  & ~clear_flags);
    unf_nxt = unf_set | (underflow & ~clear_flags);
  end

  // Output registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      counter_out    <= RESET_VALUE;
      terminal_count <= 1'b0;
      overflow       <= 1'b0;
      underflow      <= 1'b0;
    end else begin
      counter_out    <= count_nxt;
      terminal_count <= tc_nxt;
      overflow       <= ovf_nxt;
      underflow      <= unf_nxt;
    end
  end

endmodule

// File: tb/tb_updown_mod_counter.sv
// Self-checking bench for updown_mod_counter (WIDTH=4): directed sequences with
// literal expectations plus a per-cycle comparison against a behavioural model.
module tb_updown_mod_counter;

  localparam int unsigned W  = 4;
  localparam int          RV = 0;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         enable = 1'b0;
  logic         up_down = 1'b1;
  logic         load = 1'b0;
  logic [W-1:0] load_value = '0;
  logic [W-1:0] max_value = 4'd9;
  logic         saturate = 1'b0;
  logic         clear_flags = 1'b0;
  logic [W-1:0] counter_out;
  logic         terminal_count;
  logic         overflow;
  logic         underflow;

  int n_checks = 0;
  int n_fail   = 0;

  updown_mod_counter #(.WIDTH(W), .RESET_VALUE(W'(RV))) dut (
    .clk(clk), .reset(reset), .enable(enable), .up_down(up_down),
    .load(load), .load_value(load_value), .max_value(max_value),
    .saturate(saturate), .clear_flags(clear_flags),
    .counter_out(counter_out), .terminal_count(terminal_count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: the spec's rules in plain integer arithmetic.
  int m_cnt = 0;
  int m_tc  = 0;
  int m_ovf = 0;
  int m_unf = 0;
  bit m_valid = 1'b0;

  always @(posedge clk) begin
    int mx, lv;
    mx = int'(max_value);
    lv = int'(load_value);
    if (reset) begin
      m_cnt = RV; m_tc = 0; m_ovf = 0; m_unf = 0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      m_tc = 0;
      if (clear_flags) begin
        m_ovf = 0; m_unf = 0;
      end
      if (load) begin
        m_cnt = (lv < mx) ? lv : mx;
      end else if (enable && up_down) begin
        if (m_cnt < mx) m_cnt = m_cnt + 1;
        else begin
          m_ovf = 1;
          if (saturate) m_cnt = mx;
          else begin m_cnt = 0; m_tc = 1; end
        end
      end else if (enable) begin
        if (m_cnt > 0) m_cnt = m_cnt - 1;
        else begin
          m_unf = 1;
          if (!saturate) begin m_cnt = mx; m_tc = 1; end
        end
      end
    end
    #1;
    if (m_valid) begin
      chk("model_count", int'(counter_out), m_cnt);
      chk("model_tc", int'(terminal_count), m_tc);
      chk("model_ovf", int'(overflow), m_ovf);
      chk("model_unf", int'(underflow), m_unf);
    end
  end

  // Advance one clock; inputs change 2 time units after the edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1; load = 1'b0; enable = 1'b0; clear_flags = 1'b0;
    step();
    reset = 1'b0;
  endtask

  initial begin
    int seq_wrap[12];
    int seq_down[7];
    seq_wrap = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    seq_down = '{5, 4, 3, 2, 1, 0, 5};

    // Reset state
    max_value = 4'd9; saturate = 1'b0; up_down = 1'b1;
    do_reset();
    chk("reset_count", int'(counter_out), RV);
    chk("reset_tc", int'(terminal_count), 0);
    chk("reset_ovf", int'(overflow), 0);
    chk("reset_unf", int'(underflow), 0);

    // Wrap up-count 0..9
    enable = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("wrap_up_count", int'(counter_out), seq_wrap[i]);
      chk("wrap_up_tc", int'(terminal_count), (i == 9) ? 1 : 0);
      chk("wrap_up_ovf", int'(overflow), (i >= 9) ? 1 : 0);
    end

    // Saturating up-count, then clear
    do_reset();
    saturate = 1'b1; enable = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("sat_up_count", int'(counter_out), (i < 9) ? i + 1 : 9);
      chk("sat_up_tc", int'(terminal_count), 0);
      chk("sat_up_ovf", int'(overflow), (i >= 9) ? 1 : 0);
    end
    enable = 1'b0; clear_flags = 1'b1;
    step();
    clear_flags = 1'b0;
    chk("clear_ovf", int'(overflow), 0);
    chk("clear_hold_count", int'(counter_out), 9);

    // Wrap down-count from 0 with max 5
    do_reset();
    saturate = 1'b0; max_value = 4'd5; up_down = 1'b0; enable = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      chk("wrap_dn_count", int'(counter_out), seq_down[i]);
      chk("wrap_dn_tc", int'(terminal_count), (i == 0 || i == 6) ? 1 : 0);
      chk("wrap_dn_unf", int'(underflow), 1);
    end

    // Saturating down from 0
    do_reset();
    saturate = 1'b1; enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("sat_dn_count", int'(counter_out), 0);
      chk("sat_dn_tc", int'(terminal_count), 0);
      chk("sat_dn_unf", int'(underflow), 1);
    end

    // Load clamps to max and suppresses stepping
    do_reset();
    saturate = 1'b0; max_value = 4'd9; up_down = 1'b1; enable = 1'b1;
    load = 1'b1; load_value = 4'd14;
    step();
    chk("load_clamp_count", int'(counter_out), 9);
    chk("load_clamp_tc", int'(terminal_count), 0);
    chk("load_clamp_ovf", int'(overflow), 0);
    load_value = 4'd3;
    step();
    chk("load_3_count", int'(counter_out), 3);

    // Reset overrides load/enable while counting at 7 with a flag set
    load = 1'b0; load_value = 4'd0; up_down = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("pre_unf", int'(underflow), 1);
    chk("pre_count", int'(counter_out), 9);
    load = 1'b1; load_value = 4'd6;
    step();
    load = 1'b0; up_down = 1'b1;
    step();
    chk("at7_count", int'(counter_out), 7);
    reset = 1'b1; load = 1'b1; load_value = 4'd2; enable = 1'b1;
    step();
    chk("rst_ovr_count", int'(counter_out), RV);
    chk("rst_ovr_unf", int'(underflow), 0);
    chk("rst_ovr_ovf", int'(overflow), 0);
    reset = 1'b0; load = 1'b0; enable = 1'b0;

    // Lowering max below the count: up wraps, down just decrements
    max_value = 4'd15; load = 1'b1; load_value = 4'd8;
    step();
    load = 1'b0; max_value = 4'd5; up_down = 1'b1; enable = 1'b1;
    step();
    chk("lowmax_up_count", int'(counter_out), 0);
    chk("lowmax_up_tc", int'(terminal_count), 1);
    chk("lowmax_up_ovf", int'(overflow), 1);
    enable = 1'b0; max_value = 4'd15; load = 1'b1;
    step();
    load = 1'b0; max_value = 4'd5; up_down = 1'b0; enable = 1'b1;
    step();
    chk("lowmax_dn_count", int'(counter_out), 7);
    enable = 1'b0;

    // max_value 0 with wrap: terminal_count held high, count held at 0
    do_reset();
    max_value = 4'd0; up_down = 1'b1; saturate = 1'b0; enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("max0_count", int'(counter_out), 0);
      chk("max0_tc", int'(terminal_count), 1);
    end

    // Set wins over clear in the same cycle
    clear_flags = 1'b1;
    step();
    chk("set_wins_ovf", int'(overflow), 1);
    clear_flags = 1'b0; enable = 1'b0;

    // Random stream checked by the model every edge
    for (int i = 0; i < 200; i++) begin
      reset       = ($urandom_range(31) == 0);
      load        = ($urandom_range(7) == 0);
      enable      = ($urandom_range(3) != 0);
      up_down     = 1'($urandom_range(1));
      saturate    = ($urandom_range(3) == 0);
      clear_flags = ($urandom_range(7) == 0);
      load_value  = W'($urandom_range(15));
      if ($urandom_range(15) == 0) max_value = W'($urandom_range(15));
      step();
    end
    reset = 1'b0; enable = 1'b0; load = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/updown_mod_counter.md
Name: updown_mod_counter

Overview:
Parametrised successor to the team's 4-bit enable/reset counter.
Provides an up/down counter of WIDTH bits with a programmable modulus, parallel load, and wrap or saturate mode at the range limits.
Also provides a terminal-count pulse and sticky overflow/underflow flags.
Used as the generic event/timer counter in datapath and control blocks, and as the golden-model target for the self-checking counter benches.

Parameters:
WIDTH, 8, counter and data width in bits (min 2).
RESET_VALUE, 0, value loaded into counter_out on reset; must be <= 2^WIDTH-1.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  synchronous, active-high reset; clock clk.
enable  input  1  count enable; one step per clk while high.
up_down  input  1  1 = count up, 0 = count down.
load  input  1  parallel load strobe.
load_value  input  WIDTH  value for parallel load.
max_value  input  WIDTH  upper bound of the count range [0, max_value]; sampled every cycle.
saturate  input  1  1 = hold at the bound, 0 = wrap.
clear_flags  input  1  clears overflow/underflow.
counter_out  output  WIDTH  current count, registered.
terminal_count  output  1  one-cycle pulse on a wrap event, registered.
overflow  output  1  sticky: an up-step was attempted at/above max_value.
underflow  output  1  sticky: a down-step was attempted at 0.

Behaviour:
- All outputs are registered and update only on posedge clk. There is no combinational input-to-output path.
- Reset (sync, highest priority):
  - counter_out = RESET_VALUE; terminal_count = 0; overflow = 0; underflow = 0.
  - Reset asserted mid-count overrides load/enable in that cycle.
- Priority below reset: load > enable. Idle otherwise (hold; terminal_count = 0).
- Load: counter_out <= min(load_value, max_value). Load never sets flags or terminal_count. Load with enable high loads only; no step.
- Up step (enable=1, up_down=1):
  - counter_out < max_value: counter_out + 1.
  - counter_out >= max_value (includes max_value lowered below the current count): wrap mode -> 0 and terminal_count = 1 for that cycle; saturate mode -> counter_out <= max_value, terminal_count = 0. Both modes set overflow.
- Down step (enable=1, up_down=0):
  - counter_out > 0: counter_out - 1 (also when counter_out > max_value).
  - counter_out == 0: wrap mode -> max_value and terminal_count = 1; saturate mode -> hold 0. Both modes set underflow.
- terminal_count is high for exactly the one cycle following the wrapping edge. Back-to-back wraps (max_value = 0, wrap mode, enable held) give terminal_count high continuously, with counter_out held at 0.
- max_value = 0: the range is {0}. Every step is a boundary step.
- Flags: a set event and clear_flags in the same cycle -> the flag is set (set wins). clear_flags with no event -> both flags 0 next cycle. Flags are otherwise held until reset/clear.
- Mode/direction inputs may change any cycle and take effect on the next step. No internal state beyond the outputs.
- Arithmetic is modulo 2^WIDTH internally, but results are always confined to [0, max_value] as above. No X propagation from unused inputs when enable=0 and load=0.

Test Plan:
- WIDTH=4, RESET_VALUE=0, max_value=9, wrap, up, enable held 12 cycles after reset -> counter_out 1..9, 0, 1, 2. terminal_count high only on the cycle counter_out becomes 0; overflow=1 from that cycle.
- Same config, saturate=1, 12 up-steps -> counter_out stops at 9; terminal_count never high; overflow=1 after the 10th step. Then clear_flags for 1 cycle with enable=0 -> overflow=0.
- Down from 0, max_value=5, wrap -> 5, 4, 3, 2, 1, 0, 5; terminal_count pulses twice; underflow=1. With saturate=1 -> stays 0; underflow=1.
- load=1, load_value=14, max_value=9, enable=1 -> counter_out=9, no step, flags unchanged. Then load_value=3 -> counter_out=3.
- Counting at 7, reset asserted together with load=1 and enable=1 -> counter_out=RESET_VALUE and all flags 0 on the next edge. Then a random enable/up_down/load/reset stream for 200 cycles, compared every posedge against a bench reference model.
- counter_out=8, max_value changed to 5: one up-step -> 0 (wrap) with terminal_count=1 and overflow=1. From 8, one down-step -> 7.
